instr_encoder: RTL and testbench

- Encodes load, store and branch operations from decoded fields plus a 64-bit immediate into 32-bit instruction words.
- Output is bit-exact what the core's immediate generator decodes back; this is the inverse of that path.
- Feeds the instruction-memory loader and self-test program builder.
- Two-stage valid/ready pipeline with a write-address counter and error accounting.

---
 rtl/instr_encoder.sv | 126 ++++++++++++
 tb/tb_instr_encoder.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Load/store/branch instruction encoder: decoded fields plus a 64-bit immediate
// become 32-bit words, emitted through a two-stage valid/ready pipeline.
module instr_encoder #(
  parameter int unsigned             ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]       BASE_ADDR = '0,
  parameter int unsigned             ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_kind,
  input  logic [4:0]           in_rd,
  input  logic [4:0]           in_rs1,
  input  logic [4:0]           in_rs2,
  input  logic [2:0]           in_funct3,
  input  logic [63:0]          in_imm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_instr,
  output logic [ADDR_W-1:0]    out_addr,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam logic [1:0] KIND_LOAD   = 2'b00;
  localparam logic [1:0] KIND_STORE  = 2'b01;
  localparam logic [1:0] KIND_BRANCH = 2'b10;
  localparam logic [1:0] KIND_ILL    = 2'b11;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100111;

  logic                 r_s1_valid;
  logic [31:0]          r_s1_instr;
  logic                 r_s1_err;

  logic                 r_s2_valid;
  logic [31:0]          r_s2_instr;
  logic                 r_s2_err;
  logic [ADDR_W-1:0]    r_s2_addr;

  logic [ADDR_W-1:0]    r_addr;
  logic [ERR_CNT_W-1:0] r_err_count;

  logic                 w_imm_ok;
  logic                 w_err;
  logic [6:0]           w_opcode;
  logic [31:0]          w_instr;
  logic                 w_s2_load;
  logic                 w_in_ready;
  logic                 w_accept;

  // Encoder: the immediate must fit a signed 12-bit field; rejected entries encode as 0.
  always_comb begin
    w_imm_ok = (&in_imm[63:11]) || !(|in_imm[63:11]);
    w_err    = !w_imm_ok || (in_kind == KIND_ILL);
    w_opcode = OPC_LOAD;
    w_instr  = '0;
    case (in_kind)
      KIND_STORE:  w_opcode = OPC_STORE;
      KIND_BRANCH: w_opcode = OPC_BRANCH;
      default:     w_opcode = OPC_LOAD;
    endcase
    if (!w_err) begin
      if (in_kind == KIND_LOAD) begin
        w_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, w_opcode};
      end else begin
        // Branch offsets are encoded unshifted, so imm[0] sits in bit 7 like a store.
        w_instr = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], w_opcode};
      end
    end
  end

  assign w_s2_load  = r_s1_valid && (!r_s2_valid || out_ready);
  assign w_in_ready = !r_s1_valid || w_s2_load;
  assign w_accept   = in_valid && w_in_ready;

  // Stage 1 captures the encoded word; stage 2 owns the address counter and error tally.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid  <= 1'b0;
      r_s1_instr  <= '0;
      r_s1_err    <= 1'b0;
      r_s2_valid  <= 1'b0;
      r_s2_instr  <= '0;
      r_s2_err    <= 1'b0;
      r_s2_addr   <= BASE_ADDR;
      r_addr      <= BASE_ADDR;
      r_err_count <= '0;
    end else begin
      if (w_accept) begin
        r_s1_valid <= 1'b1;
        r_s1_instr <= w_instr;
        r_s1_err   <= w_err;
      end else if (w_s2_load) begin
        r_s1_valid <= 1'b0;
      end

      if (w_s2_load) begin
        r_s2_valid <= 1'b1;
        r_s2_instr <= r_s1_instr;
        r_s2_err   <= r_s1_err;
        r_s2_addr  <= r_addr;
        if (r_s1_err) begin
          if (r_err_count != '1) begin
            r_err_count <= r_err_count + ERR_CNT_W'(1);
          end
        end else begin
          r_addr <= r_addr + ADDR_W'(4);
        end
      end else if (out_ready) begin
        r_s2_valid <= 1'b0;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_s2_valid;
  assign out_instr = r_s2_instr;
  assign out_addr  = r_s2_addr;
  assign out_err   = r_s2_err;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed table, hand-written pipeline sequences and
// randomized traffic checked against a field-level model with immediate round-trip.
module tb_instr_encoder;

  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned ERR_CNT_W = 8;
  localparam logic [31:0] BASE      = 32'h0;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [1:0]           in_kind = '0;
  logic [4:0]           in_rd = '0;
  logic [4:0]           in_rs1 = '0;
  logic [4:0]           in_rs2 = '0;
  logic [2:0]           in_funct3 = '0;
  logic [63:0]          in_imm = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic [31:0]          out_instr;
  logic [ADDR_W-1:0]    out_addr;
  logic                 out_err;
  logic [ERR_CNT_W-1:0] err_count;

  instr_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .ERR_CNT_W(ERR_CNT_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .out_err(out_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] kind; logic [4:0] rd; logic [4:0] rs1; logic [4:0] rs2; logic [2:0] f3;
    longint imm; logic [31:0] instr; logic [31:0] addr; logic err; logic [7:0] ecnt;
  } vec_t;
  typedef struct {
    logic [31:0] instr; logic [31:0] addr; logic err; longint imm; logic [1:0] kind;
  } exp_t;
  typedef struct {
    logic [31:0] instr; logic [31:0] addr; logic err; logic [7:0] ecnt;
  } obs_t;

  int n_checks = 0;
  int n_fail   = 0;
  int n_acc    = 0;
  int cyc      = 0;
  bit rand_ready = 1'b0;

  exp_t exp_q[$];
  obs_t obs_q[$];
  int unsigned m_addr = BASE;
  int unsigned m_errs = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Reference: encode from field rules with plain integer arithmetic.
  function automatic exp_t model(input logic [1:0] kind, input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [2:0] f3, input longint imm);
    exp_t e;
    int unsigned u, opc;
    e.kind = kind;
    e.imm  = imm;
    e.addr = '0;
    e.err  = (kind == 2'd3) || (imm < -2048) || (imm > 2047);
    u   = 32'(imm) & 32'hFFF;
    opc = (kind == 2'd0) ? 32'h03 : (kind == 2'd1) ? 32'h23 : 32'h67;
    if (e.err)
      e.instr = '0;
    else if (kind == 2'd0)
      e.instr = (u << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7) | opc;
    else
      e.instr = ((u >> 5) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12)
              | ((u & 32'd31) << 7) | opc;
    return e;
  endfunction

  // Immediate generator as the core decodes it.
  function automatic longint decode(input logic [31:0] w, input logic [1:0] kind);
    logic [11:0] f;
    f = (kind == 2'd0) ? w[31:20] : {w[31:25], w[11:7]};
    return {{52{f[11]}}, f};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: scoreboard of accepted requests against emitted words, plus hold stability.
  bit held = 1'b0;
  logic [31:0] h_instr, h_addr;
  logic h_err;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      exp_q.delete();
      m_addr = BASE;
      m_errs = 0;
      held   = 1'b0;
    end else begin
      if (held) begin
        check("hold_valid", out_valid, 1);
        check("hold_instr", out_instr, h_instr);
        check("hold_addr", out_addr, h_addr);
        check("hold_err", out_err, h_err);
      end
      held    = out_valid && !out_ready;
      h_instr = out_instr;
      h_addr  = out_addr;
      h_err   = out_err;
      if (out_valid && out_ready) begin
        obs_q.push_back('{out_instr, out_addr, out_err, err_count});
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got instr %h addr %h, required no output", out_instr, out_addr);
        end else begin
          e = exp_q.pop_front();
          if (e.err && m_errs < 255) m_errs++;
          check("sb_instr", out_instr, e.instr);
          check("sb_addr", out_addr, e.addr);
          check("sb_err", out_err, e.err);
          check("sb_err_count", err_count, m_errs);
          if (!e.err) check("round_trip_imm", decode(out_instr, e.kind), e.imm);
        end
      end
      if (in_valid && in_ready) begin
        n_acc++;
        e = model(in_kind, in_rd, in_rs1, in_rs2, in_funct3, longint'(in_imm));
        e.addr = m_addr;
        if (!e.err) m_addr += 4;
        exp_q.push_back(e);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  task automatic send(input logic [1:0] k, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input longint imm);
    bit done = 1'b0;
    in_valid = 1'b1; in_kind = k; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_imm = imm;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: got in_ready 0 for 300 cycles, required acceptance");
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int i = 0;
    while ((exp_q.size() != 0 || out_valid) && i < 1000) begin
      step(1);
      i++;
    end
    check({name, "_drain"}, (i < 1000), 1);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required end of test");
    $fatal(1);
  end

  vec_t tbl[8];
  int   acc_cyc[8];
  exp_t ex;
  int   n_obs;

  initial begin
    // Directed vectors; expected words worked out by hand from the layouts.
    tbl[0] = '{2'b01, 5'd0, 5'd2, 5'd7, 3'd3, 16,    32'h00713823, 32'd0,  1'b0, 8'd0};
    tbl[1] = '{2'b10, 5'd0, 5'd0, 5'd1, 3'd0, 2047,  32'h7E100FE7, 32'd4,  1'b0, 8'd0};
    tbl[2] = '{2'b00, 5'd1, 5'd1, 5'd0, 3'd2, 2048,  32'h00000000, 32'd8,  1'b1, 8'd1};
    tbl[3] = '{2'b00, 5'd5, 5'd2, 5'd0, 3'd3, -8,    32'hFF813283, 32'd8,  1'b0, 8'd1};
    tbl[4] = '{2'b01, 5'd0, 5'd3, 5'd4, 3'd1, -2049, 32'h00000000, 32'd12, 1'b1, 8'd2};
    tbl[5] = '{2'b11, 5'd1, 5'd1, 5'd1, 3'd0, 0,     32'h00000000, 32'd12, 1'b1, 8'd3};
    tbl[6] = '{2'b01, 5'd0, 5'd0, 5'd0, 3'd0, -2048, 32'h80000023, 32'd12, 1'b0, 8'd3};
    tbl[7] = '{2'b00, 5'd0, 5'd0, 5'd0, 3'd0, -1,    32'hFFF00003, 32'd16, 1'b0, 8'd3};

    step(3);
    reset = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_instr", out_instr, 0);
    check("rst_out_err", out_err, 0);
    check("rst_err_count", err_count, 0);

    // Two-cycle latency of a single load.
    in_valid = 1'b1; in_kind = 2'b00; in_rd = 5'd5; in_rs1 = 5'd2; in_funct3 = 3'd3;
    in_imm = -64'sd8;
    step(1);
    in_valid = 1'b0;
    check("lat_cycle1_valid", out_valid, 0);
    step(1);
    check("lat_cycle2_valid", out_valid, 1);
    check("lat_instr", out_instr, 32'hFF813283);
    check("lat_addr", out_addr, BASE);
    check("lat_err", out_err, 0);
    drain("lat");

    // Table, sent back-to-back.
    do_reset();
    obs_q.delete();
    for (int i = 0; i < 8; i++) begin
      send(tbl[i].kind, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].f3, tbl[i].imm);
      acc_cyc[i] = cyc;
    end
    drain("tbl");
    check("tbl_back_to_back", acc_cyc[1] - acc_cyc[0], 1);
    check("tbl_count", obs_q.size(), 8);
    for (int i = 0; i < 8 && i < obs_q.size(); i++) begin
      check($sformatf("tbl%0d_instr", i), obs_q[i].instr, tbl[i].instr);
      check($sformatf("tbl%0d_addr", i), obs_q[i].addr, tbl[i].addr);
      check($sformatf("tbl%0d_err", i), obs_q[i].err, tbl[i].err);
      check($sformatf("tbl%0d_err_count", i), obs_q[i].ecnt, tbl[i].ecnt);
    end

    // Backpressure: only two requests fit while the consumer stalls.
    do_reset();
    obs_q.delete();
    out_ready = 1'b0;
    n_acc = 0;
    fork
      begin
        for (int i = 0; i < 4; i++) send(2'b00, 5'(i + 1), 5'd3, 5'd0, 3'd2, longint'(i * 4 - 6));
      end
      begin
        step(5);
        check("bp_accepted", n_acc, 2);
        check("bp_in_ready", in_ready, 0);
        out_ready = 1'b1;
      end
    join
    drain("bp");
    check("bp_count", obs_q.size(), 4);
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      ex = model(2'b00, 5'(i + 1), 5'd3, 5'd0, 3'd2, longint'(i * 4 - 6));
      check($sformatf("bp%0d_instr", i), obs_q[i].instr, ex.instr);
      check($sformatf("bp%0d_addr", i), obs_q[i].addr, BASE + 32'(i * 4));
    end

    // Reset with both stages occupied discards everything.
    do_reset();
    obs_q.delete();
    out_ready = 1'b0;
    send(2'b11, 5'd0, 5'd0, 5'd0, 3'd0, 0);
    send(2'b00, 5'd9, 5'd4, 5'd0, 3'd1, 100);
    check("rf_full_in_ready", in_ready, 0);
    check("rf_err_count_before", err_count, 1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    out_ready = 1'b1;
    step(5);
    check("rf_no_output", obs_q.size(), 0);
    check("rf_out_valid", out_valid, 0);
    check("rf_err_count", err_count, 0);
    send(2'b00, 5'd1, 5'd1, 5'd0, 3'd0, 5);
    drain("rf");
    check("rf_count", obs_q.size(), 1);
    if (obs_q.size() > 0) check("rf_addr_restart", obs_q[0].addr, BASE);

    // Random legal traffic (round trip), then mixed traffic, under random backpressure.
    do_reset();
    obs_q.delete();
    rand_ready = 1'b1;
    for (int i = 0; i < 1000; i++)
      send(2'($urandom_range(0, 2)), 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom),
           longint'(int'($urandom_range(0, 4095)) - 2048));
    for (int i = 0; i < 200; i++) begin
      longint imm;
      imm = ($urandom_range(0, 1) == 0) ? longint'({$urandom, $urandom})
                                        : longint'(int'($urandom_range(0, 8191)) - 4096);
      send(2'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), imm);
    end
    drain("rnd");
    rand_ready = 1'b0;
    step(1);
    out_ready = 1'b1;
    check("rnd_count", obs_q.size(), 1200);

    // Error counter saturation; address stays put across error entries.
    do_reset();
    obs_q.delete();
    for (int i = 0; i < 260; i++) send(2'b11, 5'd0, 5'd0, 5'd0, 3'd0, 0);
    drain("sat");
    check("sat_err_count", err_count, 8'hFF);
    check("sat_addr", out_addr, BASE);
    n_obs = obs_q.size();
    send(2'b00, 5'd2, 5'd2, 5'd0, 3'd0, 1);
    drain("sat_good");
    check("sat_good_count", obs_q.size(), n_obs + 1);
    if (obs_q.size() > n_obs) check("sat_good_addr", obs_q[n_obs].addr, BASE);
    check("sat_err_count_hold", err_count, 8'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
